// File: rtl/flash_xip_pkg.sv
// Shared types and frame geometry for the SPI NOR execute-in-place bridge.
package flash_xip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ACK = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int FRAME_BITS = 64;
  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  // Flash returns bytes in address order; the word is little-endian by byte.
  function automatic logic [DATA_BITS-1:0] byte_swap32(input logic [DATA_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV system clocks per SCK half-period.
// Strobes mark the system clock edge at which sck will rise or fall.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable,
  output logic rise_stb,
  output logic fall_stb,
  output logic sck
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap     = enable & (div_cnt == DIV_LAST);
  assign rise_stb = wrap & ~sck;
  assign fall_stb = wrap & sck;

  // Divider and sck phase; dropping enable returns both to the idle-low start point.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/obi_flash_xip_ctrl.sv
// Read-only XIP bridge: each OBI read becomes one SPI READ frame
// (cmd, 24-bit address, 32 data bits). Writes are acknowledged and dropped.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for a request; only state that grants
//  WR_ACK | write accepted, respond for one cycle, no SPI activity
//  SHIFT  | csn low, 64-bit frame being shifted out / data shifted in
//  DONE   | frame finished, csn high, response valid with new rdata
module obi_flash_xip_ctrl
  import flash_xip_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        busy_o
);

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_sr;
  logic [DATA_BITS-1:0]   rx_sr;
  logic [DATA_BITS-1:0]   rdata_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   sck_en;
  logic                   rise_stb;
  logic                   fall_stb;
  logic                   last_bit;
  logic                   rd_start;
  logic                   unused_inputs;

  assign unused_inputs = ^{addr_i[31:ADDR_BITS], addr_i[1:0], be_i, wdata_i};

  assign last_bit = fall_stb & (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  assign rd_start = req_i & ~we_i & (state_q == IDLE);
  assign rdata_o  = rdata_q;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable   (sck_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .sck      (spi_sck_o)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; the transaction type is decided from we_i in the grant cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = we_i ? WR_ACK : SHIFT;
      WR_ACK:  state_d = IDLE;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so an async reset forces the idle bus immediately.
  always_comb begin
    gnt_o      = req_i & (state_q == IDLE);
    rvalid_o   = (state_q == WR_ACK) | (state_q == DONE);
    busy_o     = (state_q != IDLE);
    sck_en     = (state_q == SHIFT);
    spi_csn_o  = (state_q != SHIFT);
    spi_mosi_o = (state_q == SHIFT) & tx_sr[FRAME_BITS-1];
  end

  // TX frame: loaded at grant, advanced at each sck fall; zeros fill the data phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_sr <= '0;
    end else if (rd_start) begin
      tx_sr <= {CMD_READ, addr_i[ADDR_BITS-1:2], 2'b00, {DATA_BITS{1'b0}}};
    end else if (fall_stb) begin
      tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Bit counter: one count per completed bit, held at zero outside SHIFT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                bit_cnt <= '0;
    else if (state_q != SHIFT)  bit_cnt <= '0;
    else if (fall_stb)          bit_cnt <= bit_cnt + 1'b1;
  end

  // RX assembly: sample miso on sck rise during the data half of the frame (bits 32..63).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sr <= '0;
    end else if (rise_stb && bit_cnt[BIT_CNT_W-1]) begin
      rx_sr <= {rx_sr[DATA_BITS-2:0], spi_miso_i};
    end
  end

  // Read data register: updated only when a read frame completes, so writes leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       rdata_q <= '0;
    else if (last_bit) rdata_q <= byte_swap32(rx_sr);
  end

endmodule

// File: tb/tb_obi_flash_xip_ctrl.sv
// Directed bench for the XIP bridge with a byte-addressed mode-0 SPI flash model.
module tb_obi_flash_xip_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_aux = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;

  logic        gnt, gnt1, gnt5;
  logic        rvalid, rvalid1, rvalid5;
  logic [31:0] rdata, rdata1, rdata5;
  logic        busy, busy1, busy5;
  logic [2:0]  sck_w, csn_w, mosi_w, miso_w;

  logic [7:0]  mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obi_flash_xip_ctrl #(.CLK_DIV(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .spi_sck_o(sck_w[0]), .spi_csn_o(csn_w[0]), .spi_mosi_o(mosi_w[0]),
    .spi_miso_i(miso_w[0]), .busy_o(busy));

  obi_flash_xip_ctrl #(.CLK_DIV(1)) dut_d1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_aux), .gnt_o(gnt1), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid1), .rdata_o(rdata1),
    .spi_sck_o(sck_w[1]), .spi_csn_o(csn_w[1]), .spi_mosi_o(mosi_w[1]),
    .spi_miso_i(miso_w[1]), .busy_o(busy1));

  obi_flash_xip_ctrl #(.CLK_DIV(5)) dut_d5 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_aux), .gnt_o(gnt5), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid5), .rdata_o(rdata5),
    .spi_sck_o(sck_w[2]), .spi_csn_o(csn_w[2]), .spi_mosi_o(mosi_w[2]),
    .spi_miso_i(miso_w[2]), .busy_o(busy5));

  // SPI NOR model per DUT: captures cmd+address, then returns 4 bytes from mem.
  for (genvar g = 0; g < 3; g++) begin : g_flash
    logic [31:0] hdr = '0;
    logic [31:0] dout = '0;
    logic [7:0]  a = '0;
    int          nbits = 0;
    int          rises = 0;
    bit          act = 1'b0;
    bit          sck_p = 1'b0;
    bit          mosi_nz = 1'b0;
    logic        miso_q = 1'b0;

    always @(csn_w[g] or sck_w[g]) begin
      if (csn_w[g]) begin
        act = 1'b0;
      end else if (!act) begin
        act = 1'b1; nbits = 0; rises = 0; hdr = '0; mosi_nz = 1'b0; miso_q = 1'b0;
      end else if (sck_w[g] && !sck_p) begin
        rises++;
        if (nbits < 32) hdr = {hdr[30:0], mosi_w[g]};
        else if (mosi_w[g]) mosi_nz = 1'b1;
        nbits++;
        if (nbits == 32) begin
          a = hdr[7:0];
          dout = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
        end
      end else if (!sck_w[g] && sck_p && nbits >= 32 && nbits < 64) begin
        miso_q = dout[31];
        dout = {dout[30:0], 1'b0};
      end
      sck_p = sck_w[g];
    end

    assign miso_w[g] = miso_q;
  end

  // Bus monitors sampled away from the active edge.
  int csn_low_cnt = 0;
  int high_run = 0;
  int last_gap = 0;
  int sck_hi1 = 0;
  int sck_hi5 = 0;
  always @(negedge clk) begin
    if (csn_w[0]) begin
      high_run++;
    end else begin
      if (high_run > 0) last_gap = high_run;
      high_run = 0;
      csn_low_cnt++;
    end
    if (sck_w[1]) sck_hi1++;
    if (sck_w[2]) sck_hi5++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one read on the CLK_DIV=2 DUT and return grant-to-rvalid latency.
  task automatic rd_main(input logic [31:0] a, output int lat);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1 chk("rd_gnt_T0", 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!rvalid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, lat2, n1, n5, cnt, snap, s1, s5, w;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_csn",    32'(csn_w[0]),  32'd1);
    chk("rst_sck",    32'(sck_w[0]),  32'd0);
    chk("rst_mosi",   32'(mosi_w[0]), 32'd0);
    chk("rst_rvalid", 32'(rvalid),    32'd0);
    chk("rst_rdata",  rdata,          32'h0);
    chk("rst_busy",   32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_gnt_noreq", 32'(gnt), 32'd0);

    // 1: basic read
    rd_main(32'h2000_0010, lat);
    chk("t1_latency", lat,               32'd257);
    chk("t1_rdata",   rdata,             32'h4433_2211);
    chk("t1_hdr",     g_flash[0].hdr,    32'h0300_0010);
    chk("t1_rises",   g_flash[0].rises,  32'd64);
    chk("t1_mosi0",   32'(g_flash[0].mosi_nz), 32'd0);
    chk("t1_csn_done", 32'(csn_w[0]),    32'd1);
    @(negedge clk);
    chk("t1_rvalid_pulse", 32'(rvalid), 32'd0);
    chk("t1_rdata_held", rdata, 32'h4433_2211);

    // 2: address masking
    rd_main(32'h2012_3457, lat);
    chk("t2_latency", lat,            32'd257);
    chk("t2_hdr",     g_flash[0].hdr, 32'h0312_3454);
    chk("t2_rdata",   rdata,          32'h0D0C_0F0E);

    // 3: write is acked and dropped
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h2000_0000; wdata = 32'hDEAD_BEEF;
    #1 chk("t3_gnt_T0", 32'(gnt), 32'd1);
    snap = csn_low_cnt;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("t3_rvalid_T1", 32'(rvalid), 32'd1);
    chk("t3_rdata_kept", rdata, 32'h0D0C_0F0E);
    chk("t3_csn_T1", 32'(csn_w[0]), 32'd1);
    @(negedge clk);
    chk("t3_rvalid_pulse", 32'(rvalid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_no_spi", csn_low_cnt - snap, 32'd0);

    // 4: back-to-back with req held
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0000;
    #1 chk("t4_gnt1", 32'(gnt), 32'd1);
    @(negedge clk);
    chk("t4_no_gnt_busy", 32'(gnt), 32'd0);
    lat = 1;
    while (!rvalid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_latency1", lat, 32'd257);
    chk("t4_rdata1", rdata, 32'h5958_5B5A);
    chk("t4_no_gnt_done", 32'(gnt), 32'd0);
    addr = 32'h0000_0010;
    @(negedge clk);
    #1 chk("t4_gnt2", 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0;
    lat2 = 1;
    while (!rvalid && lat2 < 2000) begin
      @(negedge clk);
      lat2++;
    end
    chk("t4_latency2", lat2, 32'd257);
    chk("t4_rdata2", rdata, 32'h4433_2211);
    chk("t4_csn_gap", last_gap, 32'd2);

    // 5: reset in the middle of a read
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h2000_0000;
    @(negedge clk);
    req = 1'b0;
    w = 0;
    while (g_flash[0].nbits < 41 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("t5_reached_bit40", 32'(g_flash[0].nbits >= 41), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_csn",    32'(csn_w[0]), 32'd1);
    chk("t5_sck",    32'(sck_w[0]), 32'd0);
    chk("t5_rvalid", 32'(rvalid),   32'd0);
    chk("t5_busy",   32'(busy),     32'd0);
    chk("t5_rdata",  rdata,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_main(32'h2000_0010, lat);
    chk("t5_latency", lat, 32'd257);
    chk("t5_rdata_after", rdata, 32'h4433_2211);
    chk("t5_hdr_after", g_flash[0].hdr, 32'h0300_0010);

    // 6: CLK_DIV=1 and CLK_DIV=5 builds
    @(negedge clk);
    req_aux = 1'b1; we = 1'b0; addr = 32'h2000_0010;
    #1;
    chk("t6_gnt_d1", 32'(gnt1), 32'd1);
    chk("t6_gnt_d5", 32'(gnt5), 32'd1);
    s1 = sck_hi1; s5 = sck_hi5;
    n1 = 0; n5 = 0; cnt = 0;
    while (n5 == 0 && cnt < 2000) begin
      @(negedge clk);
      req_aux = 1'b0;
      cnt++;
      if (rvalid1 && n1 == 0) n1 = cnt;
      if (rvalid5) n5 = cnt;
    end
    chk("t6_latency_d1", n1, 32'd129);
    chk("t6_latency_d5", n5, 32'd641);
    chk("t6_rdata_d1", rdata1, 32'h4433_2211);
    chk("t6_rdata_d5", rdata5, 32'h4433_2211);
    chk("t6_sck_hi_d1", sck_hi1 - s1, 32'd64);
    chk("t6_sck_hi_d5", sck_hi5 - s5, 32'd320);
    chk("t6_hdr_d1", g_flash[1].hdr, 32'h0300_0010);
    chk("t6_hdr_d5", g_flash[2].hdr, 32'h0300_0010);
    @(negedge clk);
    chk("t6_idle_d1", 32'(busy1), 32'd0);
    chk("t6_idle_d5", 32'(busy5), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
